// File: rtl/tl_a_burst_arbiter.sv
// Round-robin grant logic for an M-to-1 TileLink A channel. The arbiter picks one
// master per message and holds that grant for every beat of a multi-beat message.
// Grant is combinational from registered state (zero-cycle latency when idle).
module tl_a_burst_arbiter #(
   parameter int M        = 2,
   parameter int TL_DW    = 32,
   parameter int TL_SZ    = 4,
   parameter int MAX_SIZE = 12
) (
   input  logic                   tilelink_clock_i,
   input  logic                   tilelink_reset_ni,
   input  logic [M-1:0]           req_valid,
   input  logic [3*M-1:0]         req_opcode,
   input  logic [TL_SZ*M-1:0]     req_size,
   input  logic                   beat_ready,
   output logic [M-1:0]           grant,
   output logic [$clog2(M)-1:0]   grant_idx,
   output logic                   grant_valid,
   output logic                   arb_fire,
   output logic                   locked,
   output logic                   size_err
);

   localparam int IW = $clog2(M);
   // lg2 of the bus width in bytes: sizes at or below this fit in one beat
   localparam int LG = $clog2(TL_DW / 8);
   // wide enough to hold the largest beat count minus one
   localparam int BW = MAX_SIZE - LG + 1;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_BURST = 1'b1;

   logic          st_q, st_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [BW-1:0] beats_left_q, beats_left_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] cand_sel;
   int            cand;

   logic [2:0]       head_op;
   logic [TL_SZ-1:0] head_sz;
   logic             size_over;
   logic [BW-1:0]    beats_m1;
   logic             in_burst;

   assign in_burst = (st_q == ST_BURST);

   // Round-robin scan starting just after the last master served
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_sel  = '0;
      for (int i = 1; i <= M; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= M) cand = cand - M;
         cand_sel = IW'(cand);
         if (!win_found && req_valid[cand_sel]) begin
            win_found = 1'b1;
            win_idx   = cand_sel;
         end
      end
   end

   // Select the winner's head-beat opcode and size
   always_comb begin
      head_op = '0;
      head_sz = '0;
      for (int n = 0; n < M; n++) begin
         if (win_idx == IW'(n)) begin
            head_op = req_opcode[3*n +: 3];
            head_sz = req_size[TL_SZ*n +: TL_SZ];
         end
      end
   end

   // Beat count (minus one) of the winning message; oversize messages count as one beat
   always_comb begin
      size_over = (int'(head_sz) > MAX_SIZE);
      beats_m1  = '0;
      if ((head_op <= 3'd3) && !size_over && (int'(head_sz) > LG))
         beats_m1 = BW'((1 << (int'(head_sz) - LG)) - 1);
   end

   // Grant outputs: the locked master during a burst, otherwise the scan winner
   always_comb begin
      grant_idx   = '0;
      grant       = '0;
      grant_valid = 1'b0;
      if (in_burst) begin
         grant_idx   = lock_idx_q;
         grant       = M'(1) << lock_idx_q;
         grant_valid = req_valid[lock_idx_q];
      end else if (win_found) begin
         grant_idx   = win_idx;
         grant       = M'(1) << win_idx;
         grant_valid = 1'b1;
      end
      arb_fire = grant_valid & beat_ready;
      locked   = in_burst;
      size_err = arb_fire & ~in_burst & size_over;
   end

   // Next-state: open a burst on a multi-beat first beat, count beats down while locked
   always_comb begin
      st_d         = st_q;
      lock_idx_d   = lock_idx_q;
      beats_left_d = beats_left_q;
      rr_ptr_d     = rr_ptr_q;
      if (arb_fire) begin
         if (!in_burst) begin
            if (beats_m1 != '0) begin
               st_d         = ST_BURST;
               lock_idx_d   = win_idx;
               beats_left_d = beats_m1;
            end else begin
               rr_ptr_d = win_idx;
            end
         end else begin
            // beats_left is >= 1 whenever we are locked, so this cannot underflow
            beats_left_d = beats_left_q - BW'(1);
            if (beats_left_q == BW'(1)) begin
               st_d     = ST_IDLE;
               rr_ptr_d = lock_idx_q;
            end
         end
      end
   end

   // State registers; reset leaves master 0 with first priority
   always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
      if (!tilelink_reset_ni) begin
         st_q         <= ST_IDLE;
         lock_idx_q   <= '0;
         beats_left_q <= '0;
         rr_ptr_q     <= IW'(M - 1);
      end else begin
         st_q         <= st_d;
         lock_idx_q   <= lock_idx_d;
         beats_left_q <= beats_left_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_tl_a_burst_arbiter.sv
// Directed bench for tl_a_burst_arbiter (M=2, TL_DW=32). Inputs change on the
// falling edge and outputs are checked 1 ns later, before the next rising edge.
module tb_tl_a_burst_arbiter;

   localparam logic [2:0] GET = 3'd4;
   localparam logic [2:0] PUT = 3'd0;

   logic       clk;
   logic       rst_n;
   logic [1:0] rv;
   logic [5:0] op;
   logic [7:0] sz;
   logic       rdy;
   logic [1:0] grant;
   logic [0:0] grant_idx;
   logic       grant_valid;
   logic       arb_fire;
   logic       locked;
   logic       size_err;

   int n_assert;
   int n_fail;
   int fire1_cnt;

   tl_a_burst_arbiter #(.M(2), .TL_DW(32), .TL_SZ(4), .MAX_SIZE(12)) dut (
      .tilelink_clock_i  (clk),
      .tilelink_reset_ni (rst_n),
      .req_valid         (rv),
      .req_opcode        (op),
      .req_size          (sz),
      .beat_ready        (rdy),
      .grant             (grant),
      .grant_idx         (grant_idx),
      .grant_valid       (grant_valid),
      .arb_fire          (arb_fire),
      .locked            (locked),
      .size_err          (size_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle check of grant/fire/locked plus the global invariants
   task automatic step(input string tag, input logic [1:0] g, input logic f, input logic l);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".fire"}, 32'(arb_fire), 32'(f));
      chk({tag, ".locked"}, 32'(locked), 32'(l));
      chk({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
      chk({tag, ".fire_needs_ready"}, 32'(arb_fire & ~rdy), 32'd0);
      if (arb_fire && grant == 2'b10) fire1_cnt++;
      $display("%0t %s rv=%b rdy=%b grant=%b fire=%b locked=%b size_err=%b",
               $time, tag, rv, rdy, grant, arb_fire, locked, size_err);
   endtask

   task automatic drive(input logic [1:0] v, input logic [2:0] o1, input logic [3:0] s1,
                        input logic [2:0] o0, input logic [3:0] s0, input logic r);
      @(negedge clk);
      rv  = v;
      op  = {o1, o0};
      sz  = {s1, s0};
      rdy = r;
      #1;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      rv    = 2'b00;
      rdy   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      fire1_cnt = 0;
      rst_n = 1'b0;
      rv    = 2'b00;
      op    = '0;
      sz    = '0;
      rdy   = 1'b0;

      // Reset state
      @(negedge clk);
      #1;
      step("reset", 2'b00, 1'b0, 1'b0);
      chk("reset.size_err", 32'(size_err), 32'd0);
      chk("reset.grant_valid", 32'(grant_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1) single Get from master 0
      drive(2'b01, GET, 4'd0, GET, 4'd2, 1'b1);
      step("t1.get", 2'b01, 1'b1, 1'b0);
      chk("t1.idx", 32'(grant_idx), 32'd0);
      // rr_ptr now 0: with both valid and stalled master 1 wins, nothing fires
      drive(2'b11, GET, 4'd0, GET, 4'd2, 1'b0);
      step("t1.after", 2'b10, 1'b0, 1'b0);
      chk("t1.gv_stalled", 32'(grant_valid), 32'd1);

      // 2) alternating Gets from reset
      reset_pulse();
      drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
      step("t2.m0", 2'b01, 1'b1, 1'b0);
      drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
      step("t2.m1", 2'b10, 1'b1, 1'b0);
      chk("t2.idx1", 32'(grant_idx), 32'd1);
      drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
      step("t2.m0b", 2'b01, 1'b1, 1'b0);
      drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
      step("t2.m1b", 2'b10, 1'b1, 1'b0);
      drive(2'b11, GET, 4'd2, GET, 4'd2, 1'b1);
      step("t2.m0c", 2'b01, 1'b1, 1'b0);

      // 3+4) master 1 PutFull 16B = 4 beats, with stalls and bubbles
      fire1_cnt = 0;
      drive(2'b11, PUT, 4'd4, GET, 4'd2, 1'b1);
      step("t3.fire1", 2'b10, 1'b1, 1'b0);
      // head opcode/size change mid-burst must be ignored
      drive(2'b11, GET, 4'd0, GET, 4'd2, 1'b1);
      step("t3.fire2", 2'b10, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, GET, 4'd0, GET, 4'd2, 1'b0);
         step("t4.stall", 2'b10, 1'b0, 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         drive(2'b01, GET, 4'd0, GET, 4'd2, 1'b1);
         step("t4.bubble", 2'b10, 1'b0, 1'b1);
         chk("t4.bubble_gv", 32'(grant_valid), 32'd0);
      end
      drive(2'b11, GET, 4'd0, GET, 4'd2, 1'b1);
      step("t3.fire3", 2'b10, 1'b1, 1'b1);
      drive(2'b11, GET, 4'd0, GET, 4'd2, 1'b1);
      step("t3.fire4", 2'b10, 1'b1, 1'b1);
      drive(2'b11, GET, 4'd0, GET, 4'd2, 1'b1);
      step("t3.next_m0", 2'b01, 1'b1, 1'b0);
      chk("t3.fire_count", 32'(fire1_cnt), 32'd4);

      // 5) oversize PutFull: size_err pulse, one beat only
      drive(2'b10, PUT, 4'd13, GET, 4'd2, 1'b1);
      step("t5.oversize", 2'b10, 1'b1, 1'b0);
      chk("t5.size_err", 32'(size_err), 32'd1);
      drive(2'b00, GET, 4'd0, GET, 4'd2, 1'b1);
      step("t5.after", 2'b00, 1'b0, 1'b0);
      chk("t5.size_err_clr", 32'(size_err), 32'd0);

      // Boundary: size 3 on a 4-byte bus is exactly 2 beats
      drive(2'b01, GET, 4'd0, PUT, 4'd3, 1'b1);
      step("b.sz3_fire1", 2'b01, 1'b1, 1'b0);
      chk("b.sz3_size_err", 32'(size_err), 32'd0);
      drive(2'b01, GET, 4'd0, PUT, 4'd3, 1'b1);
      step("b.sz3_fire2", 2'b01, 1'b1, 1'b1);
      drive(2'b00, GET, 4'd0, PUT, 4'd3, 1'b1);
      step("b.sz3_done", 2'b00, 1'b0, 1'b0);
      // Boundary: size 2 fills one beat exactly, no burst
      drive(2'b01, GET, 4'd0, PUT, 4'd2, 1'b1);
      step("b.sz2_fire", 2'b01, 1'b1, 1'b0);
      drive(2'b00, GET, 4'd0, PUT, 4'd2, 1'b1);
      step("b.sz2_done", 2'b00, 1'b0, 1'b0);

      // 6) reset after beat 2 of a 4-beat burst from master 0
      drive(2'b01, GET, 4'd0, PUT, 4'd4, 1'b1);
      step("t6.fire1", 2'b01, 1'b1, 1'b0);
      drive(2'b01, GET, 4'd0, PUT, 4'd4, 1'b1);
      step("t6.fire2", 2'b01, 1'b1, 1'b1);
      @(negedge clk);
      rv = 2'b11;
      op = {GET, GET};
      #2;
      rst_n = 1'b0;
      #1;
      step("t6.in_reset", 2'b01, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      step("t6.release_m0", 2'b01, 1'b1, 1'b0);
      drive(2'b11, GET, 4'd0, GET, 4'd0, 1'b1);
      step("t6.then_m1", 2'b10, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
